ual_seq: RTL and testbench

Parametrised sequential ALU. It is the successor to the team's combinational M-bit ALU.
- Adds a valid/ready handshake on input and output.
- Registers the result and the Z/N/C/V flags.
- Runs multiply, divide and modulo as iterative multi-cycle operations; the old block used combinational arrays.
- Sits between the operand/control source (register file or test harness) and the result sink on the FPGA lab datapath.

---
 rtl/ual_pkg.sv | 31 +++
 rtl/ual_seq_if.sv | 34 +++
 rtl/ual_divider.sv | 58 +++++
 rtl/ual_seq.sv | 219 +++++++++++++++++++++
 tb/tb_ual_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ual_pkg.sv
// ual_pkg: shared constants for the sequential ALU.
//   CW          opcode width
//   op_e        opcode encodings (ADD..SRL), 10..15 are illegal
//   IDLE/BUSY/DONE  FSM state encodings
//   op_illegal  true for any opcode outside the defined set
package ual_pkg;

  localparam int unsigned CW = 4;

  typedef enum logic [CW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9
  } op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic op_illegal(input logic [CW-1:0] o);
    return o > OP_SRL;
  endfunction

endpackage

// File: rtl/ual_seq_if.sv
// ual_seq_if: operand/result handshake bundle of the sequential ALU.
//   in_valid/in_ready   operation handshake (A, B, op)
//   out_valid/out_ready result handshake (Q, R, Z, N, C, V, err)
//   master: operand source / result sink side; slave: the ALU.
interface ual_seq_if #(
  parameter int unsigned M = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [M-1:0]            A;
  logic [M-1:0]            B;
  logic [ual_pkg::CW-1:0]  op;
  logic                    out_valid;
  logic                    out_ready;
  logic [M-1:0]            Q;
  logic [M-1:0]            R;
  logic                    Z;
  logic                    N;
  logic                    C;
  logic                    V;
  logic                    err;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Q, R, Z, N, C, V, err
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Q, R, Z, N, C, V, err
  );

endinterface

// File: rtl/ual_divider.sv
// ual_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst            clock, asynchronous active-high reset
//   start               load dividend/divisor and begin (divisor must be non-zero)
//   dividend, divisor   operands, sampled on start
//   quotient, remainder values after the step taken in the current cycle
//   done                high during the M-th step; quotient/remainder are final then
module ual_divider #(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         done
);

  localparam int unsigned CntW = $clog2(M + 1);

  logic [M-1:0]    rem_q;
  logic [M-1:0]    quo_q;
  logic [M-1:0]    dvs_q;
  logic [CntW-1:0] cnt_q;

  logic [M:0]      shifted;
  logic [M-1:0]    sub_lo;
  logic            fits;

  // Partial remainder shifted left with the next dividend bit; it is always
  // below 2*divisor, so an M-bit difference is exact whenever it fits.
  assign shifted   = {rem_q, quo_q[M-1]};
  assign fits      = shifted >= {1'b0, dvs_q};
  assign sub_lo    = shifted[M-1:0] - dvs_q;
  assign remainder = fits ? sub_lo : shifted[M-1:0];
  assign quotient  = {quo_q[M-2:0], fits};
  assign done      = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CntW'(M);
    end else if (cnt_q != '0) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/ual_seq.sv
// ual_seq: sequential M-bit ALU with valid/ready handshakes and registered flags.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  ual_seq_if.slave: A, B, op in; Q, R, Z, N, C, V, err out
// Single-cycle ops finish one edge after acceptance; MUL/DIV/MOD iterate for
// M cycles in BUSY. Define UAL_SEQ_FAST_MUL_EN to compute MUL combinationally
// with single-cycle latency; DIV/MOD stay iterative either way.
module ual_seq
  import ual_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input logic      clk,
  input logic      rst,
  ual_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(M + 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   op_q;
  logic [M-1:0]    a_q;
  logic [CntW-1:0] cnt_q;
  logic [2*M-1:0]  prod_q, prod_d;

  logic [M-1:0]    q_q, r_q;
  logic            z_q, n_q, c_q, v_q, err_q;

  logic            accept;
  assign accept = (state_q == IDLE) && bus.in_valid;

  // Single-cycle datapath, evaluated straight from the bus in IDLE.
  logic [M:0]      add_s;
  logic [M-1:0]    sub_s;
  logic            b_zero;
  logic            shift_oob;

  assign add_s     = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_s     = bus.A - bus.B;
  assign b_zero    = (bus.B == '0);
  assign shift_oob = 32'(bus.B) >= M;

`ifdef UAL_SEQ_FAST_MUL_EN
  logic [2*M-1:0]  fast_prod;
  assign fast_prod = {{M{1'b0}}, bus.A} * {{M{1'b0}}, bus.B};
`endif

  logic [M-1:0]    sc_q, sc_r;
  logic            sc_c, sc_v, sc_err, sc_multi;

  always_comb begin
    sc_q     = '0;
    sc_r     = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = op_illegal(bus.op);
    sc_multi = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_q = add_s[M-1:0];
        sc_c = add_s[M];
        sc_v = (bus.A[M-1] == bus.B[M-1]) && (add_s[M-1] != bus.A[M-1]);
      end
      OP_SUB: begin
        sc_q = sub_s;
        sc_c = bus.A >= bus.B;
        sc_v = (bus.A[M-1] != bus.B[M-1]) && (sub_s[M-1] != bus.A[M-1]);
      end
      OP_MUL: begin
`ifdef UAL_SEQ_FAST_MUL_EN
        sc_q = fast_prod[M-1:0];
        sc_r = fast_prod[2*M-1:M];
        sc_c = |fast_prod[2*M-1:M];
`else
        sc_multi = 1'b1;
`endif
      end
      OP_DIV, OP_MOD: begin
        // Divide by zero short-circuits the iteration.
        if (b_zero) begin
          sc_q   = '1;
          sc_r   = bus.A;
          sc_err = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_AND:  sc_q = bus.A & bus.B;
      OP_OR:   sc_q = bus.A | bus.B;
      OP_XOR:  sc_q = bus.A ^ bus.B;
      OP_SLL:  sc_q = shift_oob ? '0 : (bus.A << bus.B);
      OP_SRL:  sc_q = shift_oob ? '0 : (bus.A >> bus.B);
      default: ;
    endcase
  end

  // Shift-add multiplier: upper half accumulates, multiplier bits shift out
  // of the low half, so after M steps prod_q holds the full product.
  logic [M:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_d  = {mul_sum, prod_q[M-1:1]};

  logic [M-1:0] div_quo, div_rem;
  logic         div_done;
  logic         div_start;

  assign div_start = accept && sc_multi && (bus.op != OP_MUL);

  ual_divider #(
    .M (M)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (bus.A),
    .divisor   (bus.B),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  logic busy_last;
  assign busy_last = (op_q == OP_MUL) ? (cnt_q == CntW'(1)) : div_done;

  // Next state and the result to be registered this cycle.
  logic [M-1:0] res_q, res_r;
  logic         res_c, res_v, res_err, wr;

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    res_q   = sc_q;
    res_r   = sc_r;
    res_c   = sc_c;
    res_v   = sc_v;
    res_err = sc_err;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          wr      = !sc_multi;
          state_d = sc_multi ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (busy_last) begin
          wr      = 1'b1;
          res_v   = 1'b0;
          res_err = 1'b0;
          state_d = DONE;
          if (op_q == OP_MUL) begin
            res_q = prod_d[M-1:0];
            res_r = prod_d[2*M-1:M];
            res_c = |prod_d[2*M-1:M];
          end else if (op_q == OP_DIV) begin
            res_q = div_quo;
            res_r = div_rem;
            res_c = 1'b0;
          end else begin
            res_q = div_rem;
            res_r = '0;
            res_c = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.op;
        a_q    <= bus.A;
        cnt_q  <= CntW'(M);
        prod_q <= {{M{1'b0}}, bus.B};
      end else if (state_q == BUSY) begin
        cnt_q  <= cnt_q - CntW'(1);
        prod_q <= prod_d;
      end
      if (wr) begin
        q_q   <= res_q;
        r_q   <= res_r;
        z_q   <= (res_q == '0);
        n_q   <= res_q[M-1];
        c_q   <= res_c;
        v_q   <= res_v;
        err_q <= res_err;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Q         = q_q;
  assign bus.R         = r_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ual_seq.sv
// tb_ual_seq: self-checking bench for ual_seq (M=4). Expected results are
// pushed to a scoreboard queue when an operation is driven and popped when
// the DUT presents out_valid.
module tb_ual_seq;
  import ual_pkg::*;

  localparam int unsigned M = 4;
  localparam int Span = 1 << M;
  localparam int SMax = Span / 2 - 1;
  localparam int SMin = -(Span / 2);
`ifdef UAL_SEQ_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = M + 1;
`endif

  typedef struct packed {
    logic [M-1:0] q;
    logic [M-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         err;
  } res_t;

  typedef struct packed {
    res_t res;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ual_seq_if #(.M(M)) bus ();

  ual_seq #(
    .M (M)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int q, input int r, input bit z, input bit n,
                              input bit c, input bit v, input bit err, input int lat);
    exp_t e;
    e.res.q   = q[M-1:0];
    e.res.r   = r[M-1:0];
    e.res.z   = z;
    e.res.n   = n;
    e.res.c   = c;
    e.res.v   = v;
    e.res.err = err;
    e.lat     = lat;
    return e;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b,
                                 input logic [3:0] o);
    int ia, ib, sa, sb, full, qv, rv, lat;
    bit c, v, err;
    ia = int'(a);
    ib = int'(b);
    sa = a[M-1] ? ia - Span : ia;
    sb = b[M-1] ? ib - Span : ib;
    qv = 0; rv = 0; c = 0; v = 0; err = 0; lat = 1;
    case (o)
      4'd0: begin
        full = ia + ib; qv = full % Span; c = full >= Span;
        v = (sa + sb > SMax) || (sa + sb < SMin);
      end
      4'd1: begin
        full = ia - ib; qv = (full + Span) % Span; c = ia >= ib;
        v = (sa - sb > SMax) || (sa - sb < SMin);
      end
      4'd2: begin
        full = ia * ib; qv = full % Span; rv = full / Span; c = rv != 0; lat = MulLat;
      end
      4'd3, 4'd4: begin
        if (ib == 0) begin
          qv = Span - 1; rv = ia; err = 1;
        end else begin
          qv = (o == 4'd3) ? ia / ib : ia % ib;
          rv = (o == 4'd3) ? ia % ib : 0;
          lat = M + 1;
        end
      end
      4'd5: qv = ia & ib;
      4'd6: qv = ia | ib;
      4'd7: qv = ia ^ ib;
      4'd8: qv = (ib >= M) ? 0 : (ia << ib) % Span;
      4'd9: qv = (ib >= M) ? 0 : ia >> ib;
      default: err = 1;
    endcase
    return mk(qv, rv, qv == 0, qv >= Span / 2, c, v, err, lat);
  endfunction

  function automatic res_t sample();
    res_t s;
    s.q = bus.Q; s.r = bus.R; s.z = bus.Z; s.n = bus.N;
    s.c = bus.C; s.v = bus.V; s.err = bus.err;
    return s;
  endfunction

  // Drive one operation, push its expectation, and return what the DUT shows
  // when out_valid rises plus the edge count from the accept edge.
  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [3:0] o,
                        input exp_t e, output res_t got, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.A = a; bus.B = b; bus.op = o; bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sample();
  endtask

  task automatic drain();
    int g = 0;
    while (bus.out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.op = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, sample()} !== {1'b1, 1'b0, res_t'(0)}) begin
      errors++;
      $display("FAIL reset_held got rdy/vld/res=%b/%b/%h want 1/0/0",
               bus.in_ready, bus.out_valid, sample());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, sample()} !== {1'b1, 1'b0, res_t'(0)}) begin
      errors++;
      $display("FAIL reset_release got rdy/vld/res=%b/%b/%h want 1/0/0",
               bus.in_ready, bus.out_valid, sample());
    end
  endtask

  task automatic test_addsub();
    logic [M-1:0] ta[3] = '{4'd7, 4'd3, 4'd7};
    logic [M-1:0] tb[3] = '{4'd9, 4'd5, 4'd1};
    logic [3:0]   to[3] = '{4'd0, 4'd1, 4'd0};
    exp_t te[3];
    res_t got;
    int lat;
    exp_t e;
    te[0] = mk(0, 0, 1, 0, 1, 0, 0, 1);
    te[1] = mk(14, 0, 0, 1, 0, 0, 0, 1);
    te[2] = mk(8, 0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], to[i], te[i], got, lat);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.res) begin
        errors++;
        $display("FAIL addsub_%0d result got=%h want=%h", i, got, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL addsub_%0d latency got=%0d want=%0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    res_t got;
    int lat;
    exp_t e;
    run_op(4'd13, 4'd11, OP_MUL, mk(15, 8, 0, 1, 1, 0, 0, MulLat), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res) begin
      errors++;
      $display("FAIL mul_13_11 result got=%h want=%h", got, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL mul_13_11 latency got=%0d want=%0d", lat, e.lat);
    end
  endtask

  task automatic test_div();
    res_t got;
    int lat;
    exp_t e;
    run_op(4'd13, 4'd3, OP_DIV, mk(4, 1, 0, 0, 0, 0, 0, M + 1), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL div_13_3 got=%h lat=%0d want=%h lat=%0d", got, lat, e.res, e.lat);
    end
    run_op(4'd9, 4'd0, OP_DIV, mk(15, 9, 0, 1, 0, 0, 1, 1), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL div_by_zero got=%h lat=%0d want=%h lat=%0d", got, lat, e.res, e.lat);
    end
  endtask

  task automatic test_reset_busy();
    drain();
    @(negedge clk);
    bus.A = 4'd13; bus.B = 4'd3; bus.op = OP_DIV; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.Q, bus.err} !== {1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_busy got vld/Q/err=%b/%h/%b want 0/0/0",
               bus.out_valid, bus.Q, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < M + 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL reset_discard cyc%0d got vld/rdy=%b/%b want 0/1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_shift_illegal();
    res_t got;
    int lat;
    exp_t e;
    run_op(4'd3, 4'd2, OP_SLL, mk(12, 0, 0, 1, 0, 0, 0, 1), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL sll_3_2 got=%h lat=%0d want=%h lat=%0d", got, lat, e.res, e.lat);
    end
    run_op(4'd5, 4'd6, 4'd12, mk(0, 0, 1, 0, 0, 0, 1, 1), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL illegal_op got=%h lat=%0d want=%h lat=%0d", got, lat, e.res, e.lat);
    end
  endtask

  task automatic test_backpressure();
    res_t got;
    int lat;
    exp_t e;
    drain();
    bus.out_ready = 1'b0;
    run_op(4'd2, 4'd3, OP_ADD, mk(5, 0, 0, 0, 0, 0, 0, 1), got, lat);
    e = exp_q.pop_front();
    checks++;
    if (got !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL bp_first got=%h lat=%0d want=%h lat=%0d", got, lat, e.res, e.lat);
    end
    // A new request arrives while the result is stalled; it must wait.
    @(negedge clk);
    bus.A = 4'd6; bus.B = 4'd4; bus.op = OP_SUB; bus.in_valid = 1'b1;
    exp_q.push_back(mk(2, 0, 0, 0, 1, 0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.Q} !== {1'b1, 1'b0, 4'd5}) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got vld/rdy/Q=%b/%b/%h want 1/0/5",
                 i, bus.out_valid, bus.in_ready, bus.Q);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got vld/rdy=%b/%b want 0/1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    got = sample();
    e = exp_q.pop_front();
    checks++;
    if (!bus.out_valid || got !== e.res) begin
      errors++;
      $display("FAIL bp_pending got vld=%b res=%h want vld=1 res=%h", bus.out_valid, got, e.res);
    end
  endtask

  task automatic test_back_to_back();
    res_t got;
    int lat;
    exp_t e;
    logic [M-1:0] a, b;
    logic [3:0] o;
    for (int i = 0; i < 40; i++) begin
      a = M'($urandom_range(0, Span - 1));
      b = ($urandom_range(0, 5) == 0) ? '0 : M'($urandom_range(0, Span - 1));
      o = 4'($urandom_range(0, 15));
      run_op(a, b, o, model(a, b, o), got, lat);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.res) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d a=%0d b=%0d got=%h want=%h", i, o, a, b, got, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d latency got=%0d want=%0d", i, o, lat, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_reset_busy();
    test_shift_illegal();
    test_backpressure();
    test_back_to_back();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
